regfile_scoreboard: RTL and testbench

//  Architectural integer register file plus per-register pending-write scoreboard.

---
 rtl/regfile_scoreboard_if.sv | 31 +++
 rtl/regfile_scoreboard.sv | 104 ++++++++++
 tb/tb_regfile_scoreboard.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback bundle for the register file and pending-write scoreboard.
// master: decode + writeback side; slave: the register file itself.
interface regfile_scoreboard_if #(
  parameter int XLEN = 64
);
  logic [4:0]      ra1;
  logic [4:0]      ra2;
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;
  logic            busy1;
  logic            busy2;
  logic            wvalid;
  logic [4:0]      wa;
  logic [XLEN-1:0] wd;
  logic            issue_valid;
  logic            issue_wen;
  logic [4:0]      issue_rd;
  logic            issue_ready;
  logic            flush;
  logic            sb_err;

  modport master (
    output ra1, ra2, wvalid, wa, wd, issue_valid, issue_wen, issue_rd, flush,
    input  rd1, rd2, busy1, busy2, issue_ready, sb_err
  );

  modport slave (
    input  ra1, ra2, wvalid, wa, wd, issue_valid, issue_wen, issue_rd, flush,
    output rd1, rd2, busy1, busy2, issue_ready, sb_err
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Architectural register file (x0 hardwired to zero) with two write-bypassed
// combinational read ports and a per-register pending-writer counter used by
// decode for hazard stalls. Decode increments at issue, writeback decrements.
module regfile_scoreboard #(
  parameter int XLEN   = 64,
  parameter int NREG   = 32,
  parameter int PEND_W = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  regfile_scoreboard_if.slave  bus
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [XLEN-1:0]   regs_q [NREG];
  logic [XLEN-1:0]   regs_d [NREG];
  logic [PEND_W-1:0] pend_q [NREG];
  logic [PEND_W-1:0] pend_d [NREG];
  logic              sb_err_q;
  logic              sb_err_d;

  logic              issue_ready;
  logic [NREG-1:0]   inc_vec;
  logic [NREG-1:0]   dec_vec;
  logic [PEND_W-1:0] pend1;
  logic [PEND_W-1:0] pend2;
  logic              dec1;
  logic              dec2;

  // Saturation is judged on the registered count only; a same-cycle
  // writeback to issue_rd does not relieve it, keeping this path short.
  assign issue_ready = !(bus.issue_wen && (bus.issue_rd != '0) &&
                         (pend_q[bus.issue_rd] == PEND_MAX));
  assign bus.issue_ready = issue_ready;
  assign bus.sb_err      = sb_err_q;

  // Read ports: x0 reads zero, otherwise this cycle's writeback is bypassed.
  always_comb begin
    bus.rd1 = regs_q[bus.ra1];
    bus.rd2 = regs_q[bus.ra2];
    if (bus.wvalid && (bus.wa == bus.ra1)) bus.rd1 = bus.wd;
    if (bus.wvalid && (bus.wa == bus.ra2)) bus.rd2 = bus.wd;
    if (bus.ra1 == '0) bus.rd1 = '0;
    if (bus.ra2 == '0) bus.rd2 = '0;
  end

  // Busy flags look through this cycle's retirement so the last writer
  // clears busy in the same cycle its data is bypassed.
  always_comb begin
    pend1 = pend_q[bus.ra1];
    pend2 = pend_q[bus.ra2];
    dec1  = bus.wvalid && (bus.wa == bus.ra1) && (pend1 != '0);
    dec2  = bus.wvalid && (bus.wa == bus.ra2) && (pend2 != '0);
    bus.busy1 = (bus.ra1 != '0) && ((pend1 - PEND_W'(dec1)) != '0);
    bus.busy2 = (bus.ra2 != '0) && ((pend2 - PEND_W'(dec2)) != '0);
  end

  // Per-register issue (increment) and retire (decrement) strobes.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int r = 1; r < NREG; r++) begin
      inc_vec[r] = bus.issue_valid && bus.issue_wen && (bus.issue_rd == 5'(r)) &&
                   issue_ready && !bus.flush;
      dec_vec[r] = bus.wvalid && (bus.wa == 5'(r)) && (pend_q[r] != '0);
    end
  end

  // Next-state: register write, counter update / flush, sticky error.
  always_comb begin
    regs_d   = regs_q;
    pend_d   = pend_q;
    sb_err_d = sb_err_q;
    if (bus.wvalid && (bus.wa != '0)) begin
      regs_d[bus.wa] = bus.wd;
      if ((pend_q[bus.wa] == '0) && !bus.flush) sb_err_d = 1'b1;
    end
    for (int r = 1; r < NREG; r++) begin
      if (bus.flush) begin
        pend_d[r] = '0;
      end else if (inc_vec[r] && !dec_vec[r]) begin
        pend_d[r] = pend_q[r] + 1'b1;
      end else if (dec_vec[r] && !inc_vec[r]) begin
        pend_d[r] = pend_q[r] - 1'b1;
      end
    end
    pend_d[0] = '0;
  end

  // State registers; reset clears data, counters and the error flag at once.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      regs_q   <= '{default: '0};
      pend_q   <= '{default: '0};
      sb_err_q <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      pend_q   <= pend_d;
      sb_err_q <= sb_err_d;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed vector table, hand-written reset
// sequences and a randomized run against a behavioural model.
module tb_regfile_scoreboard;

  logic clk;
  logic resetn;
  int   n_checks = 0;
  int   n_fail   = 0;

  regfile_scoreboard_if #(.XLEN(64)) bus ();

  regfile_scoreboard #(.XLEN(64), .NREG(32), .PEND_W(2)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: plain arrays and integer counts.
  logic [63:0] mregs [32];
  int          mpend [32];
  bit          merr;

  typedef struct {
    logic [4:0]  ra1, ra2;
    logic        wv;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic        iv, iw;
    logic [4:0]  ird;
    logic        fl;
    logic [63:0] e_rd1, e_rd2;
    logic        e_b1, e_b2, e_rdy, e_err;
  } vec_t;

  vec_t tbl [24];

  function automatic vec_t mk(input logic [4:0] ra1, ra2, input logic wv,
                              input logic [4:0] wa, input logic [63:0] wd,
                              input logic iv, iw, input logic [4:0] ird,
                              input logic fl, input logic [63:0] e_rd1, e_rd2,
                              input logic e_b1, e_b2, e_rdy, e_err);
    vec_t v;
    v.ra1 = ra1; v.ra2 = ra2; v.wv = wv; v.wa = wa; v.wd = wd;
    v.iv = iv; v.iw = iw; v.ird = ird; v.fl = fl;
    v.e_rd1 = e_rd1; v.e_rd2 = e_rd2; v.e_b1 = e_b1; v.e_b2 = e_b2;
    v.e_rdy = e_rdy; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [4:0] a1, a2, input logic wv, input logic [4:0] wa,
                       input logic [63:0] wd, input logic iv, iw,
                       input logic [4:0] ird, input logic fl);
    bus.ra1 = a1; bus.ra2 = a2; bus.wvalid = wv; bus.wa = wa; bus.wd = wd;
    bus.issue_valid = iv; bus.issue_wen = iw; bus.issue_rd = ird; bus.flush = fl;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      mregs[i] = '0;
      mpend[i] = 0;
    end
    merr = 1'b0;
  endtask

  function automatic logic [63:0] exp_rd(input logic [4:0] ra);
    if (ra == 0) return '0;
    if (bus.wvalid && bus.wa == ra) return bus.wd;
    return mregs[ra];
  endfunction

  function automatic logic exp_busy(input logic [4:0] ra);
    int left;
    if (ra == 0) return 1'b0;
    left = mpend[ra];
    if (bus.wvalid && bus.wa == ra && left > 0) left = left - 1;
    return left > 0;
  endfunction

  function automatic logic exp_ready();
    return !(bus.issue_wen && bus.issue_rd != 0 && mpend[bus.issue_rd] == 3);
  endfunction

  // Advance one clock and apply the rules of the held inputs to the model.
  task automatic tick_model();
    bit   rdy;
    bit   do_inc;
    bit   do_dec;
    @(posedge clk);
    #1;
    rdy    = exp_ready();
    do_inc = bus.issue_valid && bus.issue_wen && bus.issue_rd != 0 && rdy && !bus.flush;
    do_dec = bus.wvalid && bus.wa != 0 && mpend[bus.wa] > 0;
    if (bus.wvalid && bus.wa != 0) begin
      if (mpend[bus.wa] == 0 && !bus.flush) merr = 1'b1;
      mregs[bus.wa] = bus.wd;
    end
    if (bus.flush) begin
      for (int i = 0; i < 32; i++) mpend[i] = 0;
    end else begin
      if (do_inc) mpend[bus.issue_rd] = mpend[bus.issue_rd] + 1;
      if (do_dec) mpend[bus.wa] = mpend[bus.wa] - 1;
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".rd1"},   bus.rd1,         exp_rd(bus.ra1));
    chk({tag, ".rd2"},   bus.rd2,         exp_rd(bus.ra2));
    chk({tag, ".busy1"}, 64'(bus.busy1),  64'(exp_busy(bus.ra1)));
    chk({tag, ".busy2"}, 64'(bus.busy2),  64'(exp_busy(bus.ra2)));
    chk({tag, ".ready"}, 64'(bus.issue_ready), 64'(exp_ready()));
    chk({tag, ".err"},   64'(bus.sb_err), 64'(merr));
  endtask

  initial begin
    tbl[0]  = mk(0, 0, 0, 0, 64'h0,    1, 1, 0, 0, 64'h0,    64'h0,    0, 0, 1, 0);
    tbl[1]  = mk(0, 0, 1, 0, 64'hDEAD, 0, 0, 0, 0, 64'h0,    64'h0,    0, 0, 1, 0);
    tbl[2]  = mk(5, 0, 0, 0, 64'h0,    1, 1, 5, 0, 64'h0,    64'h0,    0, 0, 1, 0);
    tbl[3]  = mk(5, 0, 0, 0, 64'h0,    0, 0, 0, 0, 64'h0,    64'h0,    1, 0, 1, 0);
    tbl[4]  = mk(5, 5, 1, 5, 64'h1234, 0, 0, 0, 0, 64'h1234, 64'h1234, 0, 0, 1, 0);
    tbl[5]  = mk(5, 0, 0, 0, 64'h0,    0, 0, 0, 0, 64'h1234, 64'h0,    0, 0, 1, 0);
    tbl[6]  = mk(7, 0, 0, 0, 64'h0,    1, 1, 7, 0, 64'h0,    64'h0,    0, 0, 1, 0);
    tbl[7]  = mk(7, 0, 0, 0, 64'h0,    1, 1, 7, 0, 64'h0,    64'h0,    1, 0, 1, 0);
    tbl[8]  = mk(7, 0, 0, 0, 64'h0,    1, 1, 7, 0, 64'h0,    64'h0,    1, 0, 1, 0);
    tbl[9]  = mk(7, 0, 0, 0, 64'h0,    1, 1, 7, 0, 64'h0,    64'h0,    1, 0, 0, 0);
    tbl[10] = mk(7, 0, 1, 7, 64'h77,   1, 1, 7, 0, 64'h77,   64'h0,    1, 0, 0, 0);
    tbl[11] = mk(7, 0, 0, 0, 64'h0,    0, 1, 7, 0, 64'h77,   64'h0,    1, 0, 1, 0);
    tbl[12] = mk(7, 0, 1, 7, 64'h70,   0, 0, 0, 0, 64'h70,   64'h0,    1, 0, 1, 0);
    tbl[13] = mk(7, 0, 1, 7, 64'h71,   0, 0, 0, 0, 64'h71,   64'h0,    0, 0, 1, 0);
    tbl[14] = mk(3, 9, 0, 0, 64'h0,    1, 1, 3, 0, 64'h0,    64'h0,    0, 0, 1, 0);
    tbl[15] = mk(3, 9, 0, 0, 64'h0,    1, 1, 3, 0, 64'h0,    64'h0,    1, 0, 1, 0);
    tbl[16] = mk(3, 9, 0, 0, 64'h0,    1, 1, 9, 0, 64'h0,    64'h0,    1, 0, 1, 0);
    tbl[17] = mk(3, 9, 1, 3, 64'h55,   1, 1, 4, 1, 64'h55,   64'h0,    1, 1, 1, 0);
    tbl[18] = mk(3, 4, 0, 0, 64'h0,    0, 0, 0, 0, 64'h55,   64'h0,    0, 0, 1, 0);
    tbl[19] = mk(9, 7, 0, 0, 64'h0,    0, 0, 0, 0, 64'h0,    64'h71,   0, 0, 1, 0);
    tbl[20] = mk(12, 0, 1, 12, 64'hABC, 0, 0, 0, 0, 64'hABC, 64'h0,    0, 0, 1, 0);
    tbl[21] = mk(12, 0, 0, 0, 64'h0,   0, 0, 0, 0, 64'hABC,  64'h0,    0, 0, 1, 1);
    tbl[22] = mk(12, 0, 0, 0, 64'h0,   0, 0, 0, 1, 64'hABC,  64'h0,    0, 0, 1, 1);
    tbl[23] = mk(12, 0, 0, 0, 64'h0,   0, 0, 0, 0, 64'hABC,  64'h0,    0, 0, 1, 1);

    drive(0, 0, 0, 0, '0, 0, 0, 0, 0);
    resetn = 1'b1;

    // Reset: outputs and every register read back as zero.
    #2 resetn = 1'b0;
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, '0, 0, 1, 5, 0);
    #1;
    chk("rst.rd1",   bus.rd1, 64'h0);
    chk("rst.rd2",   bus.rd2, 64'h0);
    chk("rst.busy1", 64'(bus.busy1), 64'h0);
    chk("rst.busy2", 64'(bus.busy2), 64'h0);
    chk("rst.ready", 64'(bus.issue_ready), 64'h1);
    chk("rst.err",   64'(bus.sb_err), 64'h0);
    for (int r = 0; r < 32; r++) begin
      bus.ra1 = 5'(r);
      bus.ra2 = 5'(31 - r);
      #0.1;
      chk("rst.read1", bus.rd1, 64'h0);
      chk("rst.read2", bus.rd2, 64'h0);
    end
    @(posedge clk);
    #1;
    resetn = 1'b1;
    model_reset();

    // Directed vector table: x0, bypass, saturation, flush, error.
    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].ra1, tbl[i].ra2, tbl[i].wv, tbl[i].wa, tbl[i].wd,
            tbl[i].iv, tbl[i].iw, tbl[i].ird, tbl[i].fl);
      #3;
      chk($sformatf("vec%0d.rd1", i),   bus.rd1, tbl[i].e_rd1);
      chk($sformatf("vec%0d.rd2", i),   bus.rd2, tbl[i].e_rd2);
      chk($sformatf("vec%0d.busy1", i), 64'(bus.busy1), 64'(tbl[i].e_b1));
      chk($sformatf("vec%0d.busy2", i), 64'(bus.busy2), 64'(tbl[i].e_b2));
      chk($sformatf("vec%0d.ready", i), 64'(bus.issue_ready), 64'(tbl[i].e_rdy));
      chk($sformatf("vec%0d.err", i),   64'(bus.sb_err), 64'(tbl[i].e_err));
      tick_model();
    end

    // Asynchronous reset mid-cycle clears sb_err and the registers at once.
    drive(12, 3, 0, 0, '0, 0, 0, 0, 0);
    resetn = 1'b0;
    #1;
    chk("arst.err", 64'(bus.sb_err), 64'h0);
    chk("arst.rd12", bus.rd1, 64'h0);
    chk("arst.rd3",  bus.rd2, 64'h0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    model_reset();

    // A flushed writeback to an idle register does not raise sb_err.
    drive(13, 0, 1, 13, 64'h13, 1, 1, 13, 1);
    #3;
    chk_model("flerr");
    tick_model();
    drive(13, 0, 0, 0, '0, 0, 0, 0, 0);
    #3;
    chk("flerr.err_after", 64'(bus.sb_err), 64'h0);
    chk("flerr.data",      bus.rd1, 64'h13);
    chk("flerr.busy",      64'(bus.busy1), 64'h0);
    tick_model();

    // Randomized traffic on a narrow register window to create hazards.
    for (int c = 0; c < 800; c++) begin
      logic [4:0] wa_r;
      int         k;
      wa_r = 5'($urandom_range(0, 7));
      k    = int'($urandom_range(0, 7));
      if (mpend[k] > 0 && $urandom_range(0, 3) != 0) wa_r = 5'(k);
      drive(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 2) == 0), wa_r, {$urandom, $urandom},
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
            5'($urandom_range(0, 7)), 1'($urandom_range(0, 31) == 0));
      #3;
      chk_model("rnd");
      tick_model();
      if (c == 400) begin
        resetn = 1'b0;
        #1;
        resetn = 1'b1;
        model_reset();
      end
    end

    // Reset asserted mid-operation while a writeback is presented.
    drive(0, 0, 0, 0, '0, 0, 0, 0, 0);
    for (int i = 1; i < 4; i++) begin
      drive(0, 0, 0, 0, '0, 1, 1, 5'(i + 20), 0);
      tick_model();
    end
    drive(21, 22, 1, 23, 64'hFEED, 1, 1, 21, 0);
    #1;
    chk("mid.busy_pre", 64'(bus.busy1), 64'h1);
    resetn = 1'b0;
    #1;
    chk("mid.busy1", 64'(bus.busy1), 64'h0);
    chk("mid.busy2", 64'(bus.busy2), 64'h0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    drive(23, 21, 0, 0, '0, 0, 0, 0, 0);
    #1;
    chk("mid.nowrite", bus.rd1, 64'h0);
    chk("mid.busy21",  64'(bus.busy2), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule
